controlador_de_sequencia: RTL and testbench
===========================================

Name: controlador_de_sequencia

Overview:
- Fetch/flow sequencer for the Forth core. Owns the program counter and an internal return-address stack.
- Issues one fetch request per instruction and computes the next PC from decode flags: sequential, branch, zero-branch, call, return or halt.
- Sits between instruction memory (fetch handshake) and the decode unit. Replaces free-running PC increment with handshake-gated sequencing.

Parameters:
- ADDR_WIDTH, 16, PC / instruction-address width.
- OFFSET_WIDTH, 11, width of branch/call offset field.
- RS_DEPTH, 8, return-stack entries (power of two, >=2).
- RESET_ADDR, 0, PC value loaded on reset.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_ready  in  1  instruction word for pc_addr is valid this cycle; decode flags valid this cycle.
- stall  in  1  datapath busy; hold sequencing.
- op_branch  in  1  unconditional relative branch.
- op_zbranch  in  1  branch if tos_zero.
- op_call  in  1  relative call; push return address.
- op_return  in  1  pop return address into PC.
- op_halt  in  1  stop fetching.
- offset  in  OFFSET_WIDTH  branch/call offset.
- tos_zero  in  1  top-of-data-stack equals zero.
- pc_addr  out  ADDR_WIDTH  current fetch address, registered.
- fetch_req  out  1  fetch request to instruction memory.
- halted  out  1  sequencer in HALT.
- fault  out  1  sticky return-stack overflow/underflow.
- rs_level  out  clog2(RS_DEPTH)+1  return-stack occupancy.

Behaviour:
- Reset (asynchronous): pc_addr=RESET_ADDR, state=BOOT, fetch_req=0, halted=0, fault=0, rs_level=0. Stack contents are don't-care.
- States: BOOT, FETCH, STALL, HALT, FAULT.
- BOOT: one cycle after reset deasserts, then FETCH.
- FETCH: fetch_req=1, pc_addr stable until mem_ready.
  - On mem_ready=1 with stall=0, evaluate the flags and update pc_addr on the same edge. Stay in FETCH: back-to-back instructions, one per handshake.
  - On mem_ready=1 with stall=1, do not update PC. Go to STALL; the flags are not latched.
- STALL: fetch_req=0, PC held. When stall=0, return to FETCH and re-fetch the same pc_addr.
- Flag priority at the handshake, highest first: op_halt > op_return > op_call > op_branch > op_zbranch > sequential. Lower-priority flags are ignored.
- op_halt: PC unchanged, go to HALT. halted=1, fetch_req=0. Only reset exits HALT.
- op_return:
  - rs_level>0: pop; pc_addr <= popped value; rs_level-1.
  - rs_level==0: underflow. Go to FAULT, fault=1, PC unchanged.
- op_call:
  - rs_level<RS_DEPTH: push pc_addr+1; pc_addr <= pc_addr+offset_ext; rs_level+1.
  - rs_level==RS_DEPTH: overflow. Go to FAULT, no push, PC unchanged.
- op_branch: pc_addr <= pc_addr+offset_ext.
- op_zbranch:
  - tos_zero=1: pc_addr <= pc_addr+offset_ext.
  - tos_zero=0: pc_addr+1.
- Sequential: pc_addr+1.
- offset_ext = offset zero-extended to ADDR_WIDTH (unless the optional feature is enabled).
- All PC arithmetic is modulo 2^ADDR_WIDTH. Wrap 0xFFFF+1 gives 0x0000 silently.
- Return-stack pushed values also wrap: a call at 0xFFFF pushes 0x0000.
- FAULT: fetch_req=0, fault=1 sticky, PC and stack frozen. Only reset exits.
- mem_ready outside FETCH is ignored.
- Reset mid-handshake: the reset value wins immediately; no partial stack update survives.

Optional Feature:
- Macro: SEQ_SIGNED_OFFSET_EN.
- Defined: offset_ext = offset sign-extended from OFFSET_WIDTH, enabling backward branches/calls (offset 0x7FF = -1).
- Undefined: zero-extension only; offset 0x7FF = +2047.
- All other behaviour is identical.

Test Plan:
- Reset then 4 handshakes, no flags -> pc_addr 0,1,2,3,4; fetch_req=1 from the cycle after BOOT.
- At pc=0x0010: op_call offset=0x020 -> pc=0x0030, rs_level=1. Then op_return -> pc=0x0011, rs_level=0.
- op_zbranch offset=5 at pc=0x0008: tos_zero=1 -> 0x000D; tos_zero=0 -> 0x0009. Also assert op_branch and op_return together with rs_level=1 -> return wins.
- Nine nested calls with RS_DEPTH=8 -> the 9th sets fault=1 and fetch_req=0, PC frozen. op_return at rs_level=0 after reset -> fault=1.
- pc=0xFFFF sequential -> 0x0000. With SEQ_SIGNED_OFFSET_EN, op_branch offset=0x7FE at pc=0x0005 -> 0x0003; without it -> 0x0803.
- stall=1 during handshake at pc=0x0004 -> STALL, PC stays 0x0004 for 3 cycles, then re-fetches 0x0004. op_halt -> halted=1 until reset.

Source files
------------

// File: rtl/controlador_de_sequencia.sv
// Fetch/flow sequencer: owns the PC and a return-address stack, one fetch per handshake.
// Optional macro SEQ_SIGNED_OFFSET_EN sign-extends branch/call offsets (default: zero-extend).
module controlador_de_sequencia #(
  parameter int ADDR_WIDTH   = 16,
  parameter int OFFSET_WIDTH = 11,
  parameter int RS_DEPTH     = 8,
  parameter int RESET_ADDR   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mem_ready,
  input  logic                      stall,
  input  logic                      op_branch,
  input  logic                      op_zbranch,
  input  logic                      op_call,
  input  logic                      op_return,
  input  logic                      op_halt,
  input  logic [OFFSET_WIDTH-1:0]   offset,
  input  logic                      tos_zero,
  output logic [ADDR_WIDTH-1:0]     pc_addr,
  output logic                      fetch_req,
  output logic                      halted,
  output logic                      fault,
  output logic [$clog2(RS_DEPTH):0] rs_level
);

  localparam int PW = $clog2(RS_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    FETCH = 3'd1,
    STALL = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rs_mem [RS_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_rel;
  logic [ADDR_WIDTH-1:0] pop_val;
  logic [PW-1:0]         pop_idx;
  logic                  handshake;
  logic                  rs_full;
  logic                  rs_empty;
  logic                  do_push;

  function automatic logic [ADDR_WIDTH-1:0] extend_offset(input logic [OFFSET_WIDTH-1:0] off);
`ifdef SEQ_SIGNED_OFFSET_EN
    return {{(ADDR_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off};
`else
    return {{(ADDR_WIDTH-OFFSET_WIDTH){1'b0}}, off};
`endif
  endfunction

  // Next-PC candidates and stack status; all arithmetic wraps at the address width.
  always_comb begin
    pc_inc    = pc_addr + ADDR_WIDTH'(1);
    pc_rel    = pc_addr + extend_offset(offset);
    pop_idx   = rs_level[PW-1:0] - PW'(1);
    pop_val   = rs_mem[pop_idx];
    rs_full   = (rs_level == LW'(RS_DEPTH));
    rs_empty  = (rs_level == LW'(0));
    handshake = (state == FETCH) && mem_ready && !stall;
    do_push   = handshake && !op_halt && !op_return && op_call && !rs_full;
  end

  // Return-stack storage; rs_level gates every read, so the array needs no reset.
  always_ff @(posedge clock) begin
    if (do_push) begin
      rs_mem[rs_level[PW-1:0]] <= pc_inc;
    end
  end

  // Sequencer state, PC, stack occupancy and registered status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      pc_addr   <= ADDR_WIDTH'(RESET_ADDR);
      fetch_req <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      rs_level  <= LW'(0);
    end else begin
      case (state)
        BOOT: begin
          state     <= FETCH;
          fetch_req <= 1'b1;
        end
        FETCH: begin
          if (mem_ready && stall) begin
            // Flags are dropped here; the same word is re-fetched after the stall.
            state     <= STALL;
            fetch_req <= 1'b0;
          end else if (handshake) begin
            if (op_halt) begin
              state     <= HALT;
              halted    <= 1'b1;
              fetch_req <= 1'b0;
            end else if (op_return) begin
              if (rs_empty) begin
                state     <= FAULT;
                fault     <= 1'b1;
                fetch_req <= 1'b0;
              end else begin
                pc_addr  <= pop_val;
                rs_level <= rs_level - LW'(1);
              end
            end else if (op_call) begin
              if (rs_full) begin
                state     <= FAULT;
                fault     <= 1'b1;
                fetch_req <= 1'b0;
              end else begin
                pc_addr  <= pc_rel;
                rs_level <= rs_level + LW'(1);
              end
            end else if (op_branch || (op_zbranch && tos_zero)) begin
              pc_addr <= pc_rel;
            end else begin
              pc_addr <= pc_inc;
            end
          end else begin
            fetch_req <= 1'b1;
          end
        end
        STALL: begin
          if (!stall) begin
            state     <= FETCH;
            fetch_req <= 1'b1;
          end else begin
            fetch_req <= 1'b0;
          end
        end
        HALT: begin
          fetch_req <= 1'b0;
          halted    <= 1'b1;
        end
        FAULT: begin
          fetch_req <= 1'b0;
          fault     <= 1'b1;
        end
        default: begin
          state     <= FAULT;
          fault     <= 1'b1;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_de_sequencia.sv
// Bench for controlador_de_sequencia: vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_controlador_de_sequencia;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_ready, stall, op_branch, op_zbranch, op_call, op_return, op_halt, tos_zero;
  logic [10:0] offset;
  logic [15:0] pc_addr;
  logic        fetch_req, halted, fault;
  logic [3:0]  rs_level;

  int tests  = 0;
  int errors = 0;

  always #5 clock = ~clock;

  controlador_de_sequencia dut (
    .clock     (clock),
    .reset     (reset),
    .mem_ready (mem_ready),
    .stall     (stall),
    .op_branch (op_branch),
    .op_zbranch(op_zbranch),
    .op_call   (op_call),
    .op_return (op_return),
    .op_halt   (op_halt),
    .offset    (offset),
    .tos_zero  (tos_zero),
    .pc_addr   (pc_addr),
    .fetch_req (fetch_req),
    .halted    (halted),
    .fault     (fault),
    .rs_level  (rs_level)
  );

  // Reference model: plain integers and a queue as the return stack.
  bit m_boot, m_halted, m_fault, m_stalled;
  int m_pc;
  int m_stack[$];

  function automatic int ext(input int o);
`ifdef SEQ_SIGNED_OFFSET_EN
    return (o >= 1024) ? o - 2048 : o;
`else
    return o;
`endif
  endfunction

  function automatic void model_edge();
    int off;
    if (m_boot) begin m_boot = 1'b0; return; end
    if (m_halted || m_fault) return;
    if (m_stalled) begin
      if (!stall) m_stalled = 1'b0;
      return;
    end
    if (!mem_ready) return;
    if (stall) begin m_stalled = 1'b1; return; end
    off = ext(int'(offset));
    if (op_halt) m_halted = 1'b1;
    else if (op_return) begin
      if (m_stack.size() == 0) m_fault = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (op_call) begin
      if (m_stack.size() == 8) m_fault = 1'b1;
      else begin
        m_stack.push_back((m_pc + 1) & 32'hFFFF);
        m_pc = (m_pc + off) & 32'hFFFF;
      end
    end else if (op_branch || (op_zbranch && tos_zero)) m_pc = (m_pc + off) & 32'hFFFF;
    else m_pc = (m_pc + 1) & 32'hFFFF;
  endfunction

  task automatic set_in(input logic [7:0] ctl, input logic [10:0] off);
    {mem_ready, stall, op_halt, op_return, op_call, op_branch, op_zbranch, tos_zero} = ctl;
    offset = off;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] epc, input logic efr,
                       input logic ehl, input logic efa, input logic [3:0] elv);
    tests++;
    if (pc_addr !== epc || fetch_req !== efr || halted !== ehl || fault !== efa || rs_level !== elv) begin
      errors++;
      $display("FAIL %s: got pc=%h req=%b halt=%b fault=%b lvl=%0d, want pc=%h req=%b halt=%b fault=%b lvl=%0d",
               name, pc_addr, fetch_req, halted, fault, rs_level, epc, efr, ehl, efa, elv);
    end
  endtask

  task automatic check_model(input string name);
    check(name, 16'(m_pc), !(m_boot || m_halted || m_fault || m_stalled),
          m_halted, m_fault, 4'(m_stack.size()));
  endtask

  task automatic apply_reset();
    set_in(8'h00, 11'h000);
    reset = 1'b1;
    @(posedge clock);
    #1;
    m_boot = 1'b1; m_halted = 1'b0; m_fault = 1'b0; m_stalled = 1'b0;
    m_pc = 0;
    m_stack.delete();
    check("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic goto_ffff();
`ifdef SEQ_SIGNED_OFFSET_EN
    set_in(8'b1000_0100, 11'h7FF); step();
`else
    for (int i = 0; i < 32; i++) begin set_in(8'b1000_0100, 11'h7FF); step(); end
    set_in(8'b1000_0100, 11'h01F); step();
`endif
  endtask

  // ctl = {mem_ready, stall, op_halt, op_return, op_call, op_branch, op_zbranch, tos_zero}
  // flg = {fetch_req, halted, fault}
  typedef struct {
    logic [7:0]  ctl;
    logic [10:0] off;
    logic [15:0] pc;
    logic [2:0]  flg;
    logic [3:0]  lv;
  } vec_t;

  vec_t tv[$];

  initial begin
    tv.push_back(vec_t'{8'b0000_0000, 11'h000, 16'h0000, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0001, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0002, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0003, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0004, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1100_0000, 11'h000, 16'h0004, 3'b000, 4'd0});
    tv.push_back(vec_t'{8'b0100_0000, 11'h000, 16'h0004, 3'b000, 4'd0});
    tv.push_back(vec_t'{8'b1100_0000, 11'h000, 16'h0004, 3'b000, 4'd0});
    tv.push_back(vec_t'{8'b0000_0000, 11'h000, 16'h0004, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0005, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0006, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0007, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0008, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0010, 11'h005, 16'h0009, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0011, 11'h005, 16'h000E, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_0100, 11'h002, 16'h0010, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_1000, 11'h020, 16'h0030, 3'b100, 4'd1});
    tv.push_back(vec_t'{8'b1001_0000, 11'h000, 16'h0011, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_1000, 11'h003, 16'h0014, 3'b100, 4'd1});
    tv.push_back(vec_t'{8'b1001_0100, 11'h100, 16'h0012, 3'b100, 4'd0});
    tv.push_back(vec_t'{8'b1000_1100, 11'h004, 16'h0016, 3'b100, 4'd1});
    tv.push_back(vec_t'{8'b1011_0000, 11'h000, 16'h0016, 3'b010, 4'd1});
    tv.push_back(vec_t'{8'b1000_0000, 11'h000, 16'h0016, 3'b010, 4'd1});

    apply_reset();
    for (int i = 0; i < tv.size(); i++) begin
      set_in(tv[i].ctl, tv[i].off);
      step();
      check($sformatf("vec%0d", i), tv[i].pc, tv[i].flg[2], tv[i].flg[1], tv[i].flg[0], tv[i].lv);
    end

    // Return-stack overflow on the ninth nested call.
    apply_reset();
    set_in(8'h00, 11'h000); step();
    for (int i = 0; i < 9; i++) begin
      set_in(8'b1000_1000, 11'h001); step();
      if (i == 7) check("call_depth8", 16'h0008, 1'b1, 1'b0, 1'b0, 4'd8);
    end
    check("overflow", 16'h0008, 1'b0, 1'b0, 1'b1, 4'd8);
    set_in(8'b1001_0000, 11'h000); step(); step();
    check("fault_frozen", 16'h0008, 1'b0, 1'b0, 1'b1, 4'd8);

    // Return with an empty stack.
    apply_reset();
    set_in(8'h00, 11'h000); step();
    set_in(8'b1001_0000, 11'h000); step();
    check("underflow", 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0);

    // PC and pushed-address wrap at 0xFFFF.
    apply_reset();
    set_in(8'h00, 11'h000); step();
    goto_ffff();
    check("at_ffff", 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'd0);
    set_in(8'b1000_0000, 11'h000); step();
    check("seq_wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0);
    goto_ffff();
    set_in(8'b1000_1000, 11'h001); step();
    check("call_wrap", 16'h0000, 1'b1, 1'b0, 1'b0, 4'd1);
    set_in(8'b1000_0000, 11'h000); step();
    check("after_call_wrap", 16'h0001, 1'b1, 1'b0, 1'b0, 4'd1);
    set_in(8'b1001_0000, 11'h000); step();
    check("ret_pushed_0000", 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0);

    // Offset extension at pc=0x0005 with offset 0x7FE.
    apply_reset();
    set_in(8'h00, 11'h000); step();
    for (int i = 0; i < 5; i++) begin set_in(8'b1000_0000, 11'h000); step(); end
    set_in(8'b1000_0100, 11'h7FE); step();
`ifdef SEQ_SIGNED_OFFSET_EN
    check("branch_7fe", 16'h0003, 1'b1, 1'b0, 1'b0, 4'd0);
`else
    check("branch_7fe", 16'h0803, 1'b1, 1'b0, 1'b0, 4'd0);
`endif

    // Asynchronous reset in the middle of a call handshake.
    set_in(8'b1000_1000, 11'h010);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0);
    apply_reset();
    set_in(8'h00, 11'h000); step();
    set_in(8'b1001_0000, 11'h000); step();
    check("no_push_survives", 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0);

    // Randomized traffic against the reference model.
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((m_halted || m_fault) && $urandom_range(0, 7) == 0) apply_reset();
      mem_ready  = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 7) == 0);
      op_halt    = ($urandom_range(0, 99) == 0);
      op_return  = ($urandom_range(0, 5) == 0);
      op_call    = ($urandom_range(0, 4) == 0);
      op_branch  = ($urandom_range(0, 7) == 0);
      op_zbranch = ($urandom_range(0, 5) == 0);
      tos_zero   = ($urandom_range(0, 1) == 1);
      offset     = 11'($urandom);
      step();
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
